mac_arbiter: RTL and testbench

//   Shares one signed multiply-accumulate engine among NumReq neurons of a layer.

---
 rtl/mac_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mac_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_arbiter.sv
// mac_arbiter
//   Shares one signed multiply-accumulate engine among NumReq neurons.
//   A round-robin arbiter grants one requester. The grantee's activations,
//   weights and bias are latched in the grant cycle. The engine then
//   computes sat(sum(actv*w) + bias) at one product per cycle and returns
//   the result over a done/ack handshake.
//
// Ports
//   clk_i       clock, rising edge
//   reset_i     synchronous, active-low reset
//   req_i       per-neuron request (level)
//   actv_i      activations, requester r input k at [(r*NumInputs+k)*DataWidth +: DataWidth]
//   weights_i   weights, same packing as actv_i
//   bias_i      per-requester bias, requester r at [r*DataWidth +: DataWidth]
//   ack_o       one-hot grant pulse; operands latched in that cycle
//   done_o      one-hot; result_o is valid for that requester
//   ack_i       requester accepts its result
//   result_o    saturated signed result
//   busy_o      high whenever the engine is not idle
//   grant_id_o  index of the current or last grantee
module mac_arbiter #(
  parameter int NumReq       = 4,
  parameter int NumInputs    = 4,
  parameter int DataWidth    = 8,
  parameter int WeigthsWidth = DataWidth
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [NumReq-1:0]                        req_i,
  input  logic [NumReq*NumInputs*DataWidth-1:0]    actv_i,
  input  logic [NumReq*NumInputs*WeigthsWidth-1:0] weights_i,
  input  logic [NumReq*DataWidth-1:0]              bias_i,
  output logic [NumReq-1:0]                        ack_o,
  output logic [NumReq-1:0]                        done_o,
  input  logic [NumReq-1:0]                        ack_i,
  output logic signed [DataWidth-1:0]              result_o,
  output logic                                     busy_o,
  output logic [$clog2(NumReq > 1 ? NumReq : 2)-1:0] grant_id_o
);

  localparam int GidW  = $clog2(NumReq > 1 ? NumReq : 2);
  localparam int CntW  = $clog2(NumInputs > 1 ? NumInputs : 2);
  localparam int ProdW = DataWidth + WeigthsWidth;
  localparam int AccW  = DataWidth + WeigthsWidth + $clog2(NumInputs + 1) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_BIAS, ST_DONE} state_t;

  state_t                          r_state, w_next;
  logic [NumReq-1:0]               r_ack, r_done;
  logic signed [DataWidth-1:0]     r_result;
  logic [GidW-1:0]                 r_gid, r_rr;
  logic signed [AccW-1:0]          r_acc;
  logic [CntW-1:0]                 r_cnt;
  logic signed [DataWidth-1:0]     r_actv [NumInputs];
  logic signed [WeigthsWidth-1:0]  r_w    [NumInputs];
  logic signed [DataWidth-1:0]     r_bias;

  logic                            w_found;
  logic [GidW-1:0]                 w_gnt;
  logic signed [ProdW-1:0]         w_prod;
  logic signed [AccW-1:0]          w_prod_ext, w_bias_ext, w_sum;

  // Round-robin pick: first set request at or after the pointer, wrapping.
  // Returns {found, index}.
  function automatic logic [GidW:0] pick(input logic [NumReq-1:0] req,
                                         input logic [GidW-1:0]   rr);
    logic [GidW:0] res;
    int            idx;
    res = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = int'(rr) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!res[GidW] && req[idx]) res = {1'b1, GidW'(idx)};
    end
    return res;
  endfunction

  // Clamp the wide accumulator into the signed result range.
  function automatic logic signed [DataWidth-1:0] sat(input logic signed [AccW-1:0] v);
    logic signed [AccW-1:0] hi, lo;
    hi = {{(AccW-DataWidth+1){1'b0}}, {(DataWidth-1){1'b1}}};
    lo = ~hi;
    if (v > hi)      return {1'b0, {(DataWidth-1){1'b1}}};
    else if (v < lo) return {1'b1, {(DataWidth-1){1'b0}}};
    else             return v[DataWidth-1:0];
  endfunction

  assign {w_found, w_gnt} = pick(req_i, r_rr);

  assign w_prod     = r_actv[r_cnt] * r_w[r_cnt];
  assign w_prod_ext = {{(AccW-ProdW){w_prod[ProdW-1]}}, w_prod};
  assign w_bias_ext = {{(AccW-DataWidth){r_bias[DataWidth-1]}}, r_bias};
  assign w_sum      = r_acc + w_bias_ext;

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_next = ST_MAC;
      ST_MAC:  if (r_cnt == CntW'(NumInputs - 1)) w_next = ST_BIAS;
      ST_BIAS: w_next = ST_DONE;
      ST_DONE: if (ack_i[r_gid]) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o     = (r_state != ST_IDLE);
    ack_o      = r_ack;
    done_o     = r_done;
    result_o   = r_result;
    grant_id_o = r_gid;
  end

  // Control, accumulator and output registers
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_ack    <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_gid    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_rr     <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_ack <= NumReq'(1) << w_gnt;
            r_gid <= w_gnt;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        ST_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_cnt <= r_cnt + CntW'(1);
        end
        ST_BIAS: begin
          r_acc    <= w_sum;
          r_result <= sat(w_sum);
          r_done   <= NumReq'(1) << r_gid;
        end
        ST_DONE: begin
          if (ack_i[r_gid]) begin
            r_done <= '0;
            if (int'(r_gid) == NumReq - 1) r_rr <= '0;
            else                           r_rr <= r_gid + GidW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand latch: captured only at the grant, so later input changes
  // and dropped requests cannot disturb a running operation.
  always_ff @(posedge clk_i) begin
    if (r_state == ST_IDLE && w_found) begin
      for (int k = 0; k < NumInputs; k++) begin
        r_actv[k] <= actv_i[(int'(w_gnt)*NumInputs + k)*DataWidth +: DataWidth];
        r_w[k]    <= weights_i[(int'(w_gnt)*NumInputs + k)*WeigthsWidth +: WeigthsWidth];
      end
      r_bias <= bias_i[int'(w_gnt)*DataWidth +: DataWidth];
    end
  end

endmodule

// File: tb/tb_mac_arbiter.sv
module tb_mac_arbiter;

  logic         clk_i;
  logic         reset_i;
  logic [3:0]   req_i;
  logic [127:0] actv_i;
  logic [127:0] weights_i;
  logic [31:0]  bias_i;
  logic [3:0]   ack_o;
  logic [3:0]   done_o;
  logic [3:0]   ack_i;
  logic [7:0]   result_o;
  logic         busy_o;
  logic [1:0]   grant_id_o;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  mac_arbiter #(
    .NumReq(4), .NumInputs(4), .DataWidth(8), .WeigthsWidth(8)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .actv_i(actv_i),
    .weights_i(weights_i), .bias_i(bias_i), .ack_o(ack_o), .done_o(done_o),
    .ack_i(ack_i), .result_o(result_o), .busy_o(busy_o), .grant_id_o(grant_id_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    edge_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // a/w: input0 in the low byte
  task automatic load(input int r, input logic [31:0] a, input logic [31:0] w, input logic [7:0] b);
    actv_i[r*32 +: 32]    = a;
    weights_i[r*32 +: 32] = w;
    bias_i[r*8 +: 8]      = b;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_o == 4'b0 && k < 20) begin
      tick();
      k++;
    end
    check(tag, {31'b0, done_o != 4'b0}, 32'd1);
  endtask

  // Single request with exact latency checks, then acknowledge.
  task automatic run_one(input int r, input logic [7:0] exp, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << r;
    req_i = oh;
    tick();
    check({tag, "_ack"}, ack_o, oh);
    check({tag, "_busy"}, busy_o, 1'b1);
    check({tag, "_gid"}, grant_id_o, r);
    req_i = 4'b0;
    tick();
    check({tag, "_ackpulse"}, ack_o, 4'b0);
    tick(); tick(); tick();
    check({tag, "_done_early"}, done_o, 4'b0);
    tick();
    check({tag, "_done"}, done_o, oh);
    check({tag, "_result"}, result_o, exp);
    ack_i = oh;
    tick();
    ack_i = 4'b0;
    check({tag, "_done_clr"}, done_o, 4'b0);
    check({tag, "_idle"}, busy_o, 1'b0);
  endtask

  initial begin
    int         exp_order [5];
    int         last_edge;
    logic [7:0] b8;
    exp_order = '{0, 1, 2, 3, 0};
    reset_i   = 1'b0;
    req_i     = 4'b0;
    ack_i     = 4'b0;
    actv_i    = '0;
    weights_i = '0;
    bias_i    = '0;
    tick(); tick();
    check("rst_ack", ack_o, 4'b0);
    check("rst_done", done_o, 4'b0);
    check("rst_result", result_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_gid", grant_id_o, 2'd0);
    reset_i = 1'b1;
    tick();

    // T1: 1+2+3+4 + 5 = 15
    load(0, 32'h04030201, 32'h01010101, 8'h05);
    run_one(0, 8'h0F, "t1");

    // T2: saturation both ways
    load(0, 32'h7F7F7F7F, 32'h7F7F7F7F, 8'h7F);
    run_one(0, 8'h7F, "t2_pos");
    load(0, 32'h80808080, 32'h7F7F7F7F, 8'h00);
    run_one(0, 8'h80, "t2_neg");

    // T6: -12 -10 +7 +6 -1 = -10
    load(0, 32'h02F905FD, 32'h03FFFE04, 8'hFF);
    run_one(0, 8'hF6, "t6");

    // T5: reset during the 2nd MAC cycle
    load(2, 32'h01010101, 32'h01010101, 8'h00);
    req_i = 4'b0100;
    tick();
    check("t5_ack", ack_o, 4'b0100);
    check("t5_gid", grant_id_o, 2'd2);
    tick();
    reset_i = 1'b0;
    tick();
    check("t5_rst_done", done_o, 4'b0);
    check("t5_rst_ack", ack_o, 4'b0);
    check("t5_rst_result", result_o, 8'h00);
    check("t5_rst_busy", busy_o, 1'b0);
    check("t5_rst_gid", grant_id_o, 2'd0);
    reset_i = 1'b1;

    // T3: all requesting; requester r computes 4*(r+1). First grant after
    // the reset above also shows the pointer restarted at 0.
    for (int r = 0; r < 4; r++) begin
      b8 = 8'(r + 1);
      load(r, {4{b8}}, 32'h01010101, 8'h00);
    end
    req_i = 4'b1111;
    last_edge = 0;
    for (int n = 0; n < 5; n++) begin
      int k;
      k = 0;
      tick();
      while (ack_o == 4'b0 && k < 20) begin
        tick();
        k++;
      end
      check("t3_ack", ack_o, 4'b0001 << exp_order[n]);
      check("t3_gid", grant_id_o, exp_order[n]);
      if (n > 0) check("t3_spacing", edge_cnt - last_edge, 7);
      last_edge = edge_cnt;
      wait_done("t3_wait_done");
      check("t3_result", result_o, 4 * (exp_order[n] + 1));
      ack_i = done_o;
      tick();
      ack_i = 4'b0;
      if (n == 4) req_i = 4'b0;
    end
    tick();
    check("t3_idle", busy_o, 1'b0);

    // T4: latched operands, dropped request, stray acks
    load(2, 32'h0A0A0A0A, 32'h02020202, 8'hFD);
    req_i = 4'b0100;
    tick();
    check("t4_ack", ack_o, 4'b0100);
    req_i = 4'b0;
    load(2, 32'h7F7F7F7F, 32'h7F7F7F7F, 8'h7F);
    ack_i = 4'b1111;
    tick(); tick();
    ack_i = 4'b0;
    wait_done("t4_wait_done");
    check("t4_done", done_o, 4'b0100);
    check("t4_result", result_o, 8'd77);
    ack_i = 4'b0001;
    tick();
    check("t4_wrong_ack_done", done_o, 4'b0100);
    check("t4_wrong_ack_busy", busy_o, 1'b1);
    tick();
    check("t4_wrong_ack_hold", result_o, 8'd77);
    ack_i = 4'b0100;
    tick();
    ack_i = 4'b0;
    check("t4_done_clr", done_o, 4'b0);
    check("t4_idle", busy_o, 1'b0);
    check("t4_result_hold", result_o, 8'd77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
